// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock,
// start/busy/done handshake, divide-by-zero flagged with a one-cycle result.
module seq_restoring_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    count_reg, count_next;
  logic [WIDTH-1:0] part_reg, part_next;
  logic [WIDTH-1:0] shift_reg, shift_next;
  logic [WIDTH-1:0] divisor_reg, divisor_next;
  logic             dz_pending_reg, dz_pending_next;
  logic [WIDTH-1:0] quotient_reg, quotient_next;
  logic [WIDTH-1:0] remainder_reg, remainder_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic             dbz_reg, dbz_next;

  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] r_step;
  logic [WIDTH-1:0] q_step;

  // The kept partial remainder is always below the divisor, so its top bit
  // is zero between steps and only WIDTH bits need to be stored.
  always_comb begin
    r_shift = {1'b0, part_reg, shift_reg[WIDTH-1]} >> 0;
    r_shift = {part_reg, shift_reg[WIDTH-1]};
    trial   = r_shift - {1'b0, divisor_reg};
    if (!trial[WIDTH]) begin
      r_step = trial[WIDTH-1:0];
      q_step = {shift_reg[WIDTH-2:0], 1'b1};
    end else begin
      r_step = r_shift[WIDTH-1:0];
      q_step = {shift_reg[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    state_next      = state_reg;
    count_next      = count_reg;
    part_next       = part_reg;
    shift_next      = shift_reg;
    divisor_next    = divisor_reg;
    dz_pending_next = dz_pending_reg;
    quotient_next   = quotient_reg;
    remainder_next  = remainder_reg;
    busy_next       = busy_reg;
    done_next       = 1'b0;
    dbz_next        = dbz_reg;

    case (state_reg)
      IDLE: begin
        if (dz_pending_reg) begin
          // Zero divisor: the captured dividend still sits in shift_reg.
          quotient_next   = '1;
          remainder_next  = shift_reg;
          dbz_next        = 1'b1;
          done_next       = 1'b1;
          busy_next       = 1'b0;
          dz_pending_next = 1'b0;
        end else if (start) begin
          busy_next  = 1'b1;
          dbz_next   = 1'b0;
          shift_next = dividend;
          if (divisor != '0) begin
            state_next   = RUN;
            count_next   = CW'(WIDTH);
            part_next    = '0;
            divisor_next = divisor;
          end else begin
            dz_pending_next = 1'b1;
          end
        end
      end

      RUN: begin
        part_next  = r_step;
        shift_next = q_step;
        count_next = count_reg - CW'(1);
        if (count_reg == CW'(1)) begin
          quotient_next  = q_step;
          remainder_next = r_step;
          done_next      = 1'b1;
          dbz_next       = 1'b0;
          busy_next      = 1'b0;
          state_next     = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      count_reg      <= '0;
      part_reg       <= '0;
      shift_reg      <= '0;
      divisor_reg    <= '0;
      dz_pending_reg <= 1'b0;
      quotient_reg   <= '0;
      remainder_reg  <= '0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      dbz_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      count_reg      <= count_next;
      part_reg       <= part_next;
      shift_reg      <= shift_next;
      divisor_reg    <= divisor_next;
      dz_pending_reg <= dz_pending_next;
      quotient_reg   <= quotient_next;
      remainder_reg  <= remainder_next;
      busy_reg       <= busy_next;
      done_reg       <= done_next;
      dbz_reg        <= dbz_next;
    end
  end

  assign quotient    = quotient_reg;
  assign remainder   = remainder_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;
  assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Randomised and directed checks of seq_restoring_divider at WIDTH=4 and 16
// against a cycle-level behavioural model using plain / and %.
module tb_seq_restoring_divider;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start4;
  logic [3:0]  a4, d4, q4, r4;
  logic        busy4, done4, dz4;
  logic        start16;
  logic [15:0] a16, d16, q16, r16;
  logic        busy16, done16, dz16;

  seq_restoring_divider #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .dividend(a4), .divisor(d4),
    .quotient(q4), .remainder(r4), .busy(busy4), .done(done4), .div_by_zero(dz4)
  );

  seq_restoring_divider #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .dividend(a16), .divisor(d16),
    .quotient(q16), .remainder(r16), .busy(busy16), .done(done16), .div_by_zero(dz16)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  // Model state per instance: 0 = WIDTH 4, 1 = WIDTH 16.
  int unsigned m_cnt[2];
  int unsigned m_q[2], m_r[2], m_pq[2], m_pr[2];
  bit          m_busy[2], m_done[2], m_dz[2], m_pdz[2];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_step(input int i, input bit r, input bit s,
                            input int unsigned a, input int unsigned d, input int w);
    int unsigned mask;
    mask = (32'd1 << w) - 32'd1;
    if (r) begin
      m_cnt[i] = 0; m_q[i] = 0; m_r[i] = 0; m_busy[i] = 0; m_done[i] = 0; m_dz[i] = 0;
    end else begin
      m_done[i] = 0;
      if (m_cnt[i] != 0) begin
        m_cnt[i]--;
        if (m_cnt[i] == 0) begin
          m_done[i] = 1; m_busy[i] = 0;
          m_q[i] = m_pq[i]; m_r[i] = m_pr[i]; m_dz[i] = m_pdz[i];
        end
      end else if (s) begin
        m_busy[i] = 1;
        m_dz[i]   = 0;
        m_pdz[i]  = (d == 0);
        if (d == 0) begin
          m_pq[i] = mask; m_pr[i] = a; m_cnt[i] = 1;
        end else begin
          m_pq[i] = a / d; m_pr[i] = a % d; m_cnt[i] = w;
        end
      end
    end
  endtask

  always @(posedge clk) begin
    model_step(0, rst, start4, 32'(a4), 32'(d4), 4);
    model_step(1, rst, start16, 32'(a16), 32'(d16), 16);
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("q4", q4, m_q[0]);
      check("r4", r4, m_r[0]);
      check("busy4", busy4, m_busy[0]);
      check("done4", done4, m_done[0]);
      check("dz4", dz4, m_dz[0]);
      check("q16", q16, m_q[1]);
      check("r16", r16, m_r[1]);
      check("busy16", busy16, m_busy[1]);
      check("done16", done16, m_done[1]);
      check("dz16", dz16, m_dz[1]);
    end
  end

  // Called at a falling edge; returns at the falling edge just after the accept edge.
  task automatic launch4(input int a, input int d);
    a4 = 4'(a); d4 = 4'(d); start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    a4 = 4'($urandom); d4 = 4'($urandom);
  endtask

  task automatic await4(input string name, input int lat, input int eq, input int er, input int edz);
    int k;
    int nb;
    k = 0; nb = 0;
    while (!done4 && k < 40) begin
      if (busy4) nb++;
      @(negedge clk);
      k++;
    end
    $display("op %s: latency %0d q=%0d r=%0d dz=%0d", name, k, q4, r4, dz4);
    check({name, "_lat"}, k, lat);
    check({name, "_busy"}, nb, lat);
    check({name, "_q"}, q4, eq);
    check({name, "_r"}, r4, er);
    check({name, "_dz"}, dz4, edz);
  endtask

  initial begin
    int unsigned a, d;
    int k, nb, lat;
    rst = 1'b1;
    start4 = 1'b0; a4 = '0; d4 = '0;
    start16 = 1'b0; a16 = '0; d16 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    cmp_en = 1'b1;
    check("rst_q4", q4, 0);
    check("rst_busy4", busy4, 0);
    check("rst_done4", done4, 0);
    rst = 1'b0;
    @(negedge clk);

    launch4(13, 3); await4("13/3", 4, 4, 1, 0);
    check("model_q_13_3", m_q[0], 4);
    check("model_r_13_3", m_r[0], 1);
    launch4(15, 1); await4("15/1", 4, 15, 0, 0);
    launch4(2, 7);  await4("2/7", 4, 0, 2, 0);
    launch4(5, 0);  await4("5/0", 1, 15, 5, 1);
    check("model_dz_5_0", m_dz[0], 1);
    launch4(6, 3);
    check("dz_clear_on_start", dz4, 0);
    await4("6/3", 4, 2, 0, 0);

    // Request during busy is ignored.
    launch4(9, 2);
    a4 = 4'd14; d4 = 4'd5; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    await4("9/2_ign", 3, 4, 1, 0);
    // Back-to-back start in the done cycle.
    launch4(14, 5); await4("14/5_b2b", 4, 2, 4, 0);

    // Reset in the second RUN cycle aborts the operation.
    launch4(12, 5);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_q", q4, 0);
    check("abort_r", r4, 0);
    check("abort_busy", busy4, 0);
    check("abort_dz", dz4, 0);
    for (int i = 0; i < 8; i++) begin
      check("abort_no_done", done4, 0);
      @(negedge clk);
    end
    launch4(12, 5); await4("12/5", 4, 2, 2, 0);

    for (int ai = 0; ai < 16; ai++) begin
      for (int di = 0; di < 16; di++) begin
        launch4(ai, di);
        if (di == 0) await4($sformatf("sw%0d/%0d", ai, di), 1, 15, ai, 1);
        else await4($sformatf("sw%0d/%0d", ai, di), 4, ai / di, ai % di, 0);
      end
    end

    for (int n = 0; n < 300; n++) begin
      a = $urandom_range(0, 65535);
      case ($urandom_range(0, 5))
        0: d = 0;
        1: d = $urandom_range(1, 15);
        2: d = (a < 65535) ? a + 1 : 1;
        default: d = $urandom_range(0, 65535);
      endcase
      a16 = 16'(a); d16 = 16'(d); start16 = 1'b1;
      @(negedge clk);
      start16 = 1'b0;
      k = 0; nb = 0;
      while (!done16 && k < 60) begin
        if (busy16) nb++;
        if (busy16 && $urandom_range(0, 3) == 0) begin
          start16 = 1'b1; a16 = 16'($urandom); d16 = 16'($urandom);
        end else begin
          start16 = 1'b0;
        end
        @(negedge clk);
        k++;
      end
      start16 = 1'b0;
      lat = (d == 0) ? 1 : 16;
      $display("op16 %0d/%0d: latency %0d q=%0d r=%0d dz=%0d", a, d, k, q16, r16, dz16);
      check("r16_lat", k, lat);
      check("r16_busy", nb, lat);
      if (d == 0) begin
        check("r16_dzq", q16, 65535);
        check("r16_dzr", r16, a);
        check("r16_dz", dz16, 1);
      end else begin
        check("r16_inv", longint'(q16) * d + r16, a);
        check("r16_rem_lt", (r16 < d) ? 1 : 0, 1);
        check("r16_dz", dz16, 0);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_restoring_divider.md
Name: seq_restoring_divider

Overview:
- Multi-cycle unsigned restoring divider. It is the inverse-operation companion to the team's combinational carry-lookahead adder.
- Produces quotient and remainder of DIVIDEND / DIVISOR by iterative shift-and-trial-subtract, one quotient bit per clock.
- Sits beside the adder in the arithmetic datapath. Uses a start/busy/done handshake so a controller can launch operations and wait for results.

Parameters:
- WIDTH, 4, operand/quotient/remainder width in bits (legal range 2..32)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- dividend  input  WIDTH  unsigned numerator, captured on accepted start
- divisor  input  WIDTH  unsigned denominator, captured on accepted start
- quotient  output  WIDTH  registered result
- remainder  output  WIDTH  registered result
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when results become valid
- div_by_zero  output  1  qualifies done; high when the captured divisor was 0

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high. Polarity and synchronicity are fixed.
- Reset values: quotient=0, remainder=0, busy=0, done=0, div_by_zero=0, state=IDLE, iteration counter=0. rst overrides all other inputs, including mid-operation: the operation aborts and no done is issued.
- FSM states and transitions:
  - IDLE: on edge t0 with start=1, capture operands.
    - If divisor!=0: go to RUN, load counter=WIDTH, partial remainder (WIDTH+1 bits)=0, shift register=dividend.
    - If divisor==0: stay IDLE. At edge t0+1 set quotient=all ones, remainder=dividend, div_by_zero=1, done=1. busy is high during cycle t0..t0+1.
  - RUN: one iteration per edge.
    - r' = {r[WIDTH-1:0], q[WIDTH-1]}, q shifted left.
    - t = r' - divisor (WIDTH+1-bit borrow subtract).
    - If t nonnegative (MSB=0): r=t, q[0]=1. Otherwise r=r', q[0]=0.
    - Counter decrements. When the counter reaches 0 on edge t0+WIDTH: register quotient=q and remainder=r[WIDTH-1:0], pulse done=1, div_by_zero=0, return to IDLE.
- Latency: done is visible exactly WIDTH cycles after the start edge (1 cycle for divide-by-zero).
- busy: rises the cycle after an accepted start. It is high through the last RUN cycle and low in the cycle where done=1.
- done: exactly one cycle wide. It is never asserted without a preceding accepted start.
- div_by_zero: valid only while done=1. It holds its value until the next accepted start, where it clears to 0.
- quotient/remainder: hold their last values until the next completion; they are not cleared on a new start.
- Handshake rules:
  - start while busy=1 is ignored; operands are not re-sampled.
  - start in the same cycle as done=1 is accepted (back-to-back, no bubble).
  - Operands may change freely after the accept edge.
- Arithmetic: unsigned only.
  - quotient*divisor + remainder == dividend.
  - remainder < divisor.
  - dividend < divisor gives quotient=0, remainder=dividend.
- No combinational path from inputs to outputs.

Test Plan:
- WIDTH=4, reset then start with dividend=13, divisor=3 -> busy high 4 cycles; done pulses at start edge+4 with quotient=4, remainder=1, div_by_zero=0.
- dividend=15, divisor=1 -> quotient=15, remainder=0; dividend=2, divisor=7 -> quotient=0, remainder=2.
- dividend=5, divisor=0 -> done at start edge+1 with div_by_zero=1, quotient=15, remainder=5; next valid op clears div_by_zero.
- Start 9/2, then assert start with 14/5 during busy -> second request ignored, result quotient=4, remainder=1. Then start 14/5 in the done cycle -> accepted, quotient=2, remainder=4 exactly 4 cycles later.
- Assert rst for 1 cycle in the 2nd RUN cycle of 12/5 -> all outputs 0, no done pulse. A subsequent 12/5 completes with quotient=2, remainder=2.
- Exhaustive sweep of all 256 operand pairs at WIDTH=4, then randomized at WIDTH=16 -> every result matches the reference model and the invariants, with done latency exactly WIDTH (1 for divide-by-zero).
